// File: rtl/wh_link_stat_pkg.sv
// Shared types for the wormhole link statistics collector: stat selectors, FSM states and
// the record layout macro.
package wh_link_stat_pkg;

   typedef enum logic [1:0] {
      XFER  = 2'd0,
      STALL = 2'd1,
      IDLE  = 2'd2,
      PKT   = 2'd3
   } wh_stat_sel_e;

   localparam int unsigned NumStats = 4;

   typedef enum logic {TrkHdr, TrkBody} wh_trk_state_e;

   typedef enum logic {DumpIdle, DumpRun} wh_dump_state_e;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int unsigned lg(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`ifndef WH_STAT_REC_S
`define WH_STAT_REC_S(id_w, ctr_w) \
   struct packed { \
      logic [(id_w)-1:0] link_id; \
      wh_link_stat_pkg::wh_stat_sel_e stat_sel; \
      logic [(ctr_w)-1:0] value; \
   }
`endif

// File: rtl/wh_link_stat_collector_if.sv
// Observed links, snapshot request and record stream of the link statistics collector.
interface wh_link_stat_collector_if
   import wh_link_stat_pkg::*;
#(
   parameter int unsigned num_links_p     = 8,
   parameter int unsigned ctr_width_p     = 32,
   parameter int unsigned wh_flit_width_p = 64
) ();

   localparam int unsigned LinkIdWidth = lg(num_links_p);
   localparam int unsigned RecWidth    = LinkIdWidth + 2 + ctr_width_p;

   logic                                   en_i;
   logic [num_links_p-1:0]                 link_v_i;
   logic [num_links_p-1:0]                 link_ready_i;
   logic [num_links_p*wh_flit_width_p-1:0] link_data_i;
   logic                                   snap_v_i;
   logic                                   snap_ready_o;
   logic                                   rec_v_o;
   logic [RecWidth-1:0]                    rec_data_o;
   logic                                   rec_last_o;
   logic                                   rec_ready_i;

   modport master (
      output en_i, link_v_i, link_ready_i, link_data_i, snap_v_i, rec_ready_i,
      input  snap_ready_o, rec_v_o, rec_data_o, rec_last_o
   );

   modport slave (
      input  en_i, link_v_i, link_ready_i, link_data_i, snap_v_i, rec_ready_i,
      output snap_ready_o, rec_v_o, rec_data_o, rec_last_o
   );

endinterface

// File: rtl/wh_link_stat_tracker.sv
// Per-link wormhole header/body tracker with saturating transfer, stall, idle and packet
// counters that can be cleared on snapshot acceptance.
module wh_link_stat_tracker
   import wh_link_stat_pkg::*;
#(
   parameter int unsigned ctr_width_p     = 32,
   parameter int unsigned wh_flit_width_p = 64,
   parameter int unsigned wh_len_offset_p = 0,
   parameter int unsigned wh_len_width_p  = 4,
   parameter bit          clear_on_snap_p = 1'b1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   en_i,
   input  logic                                   v_i,
   input  logic                                   ready_i,
   input  logic [wh_flit_width_p-1:0]             data_i,
   input  logic                                   snap_i,
   output logic [NumStats-1:0][ctr_width_p-1:0]   cnt_o
);

   wh_trk_state_e               state_q, state_d;
   logic [wh_len_width_p-1:0]   rem_q, rem_d;
   logic [wh_len_width_p-1:0]   len;
   logic                        xfer;
   logic [NumStats-1:0]         ev;
   logic [NumStats-1:0][ctr_width_p-1:0] cnt_q, cnt_d;
   logic                        unused_data;

   assign len         = data_i[wh_len_offset_p +: wh_len_width_p];
   assign xfer        = v_i & ready_i;
   assign unused_data = ^data_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= TrkHdr;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // Tracking ignores en_i so packet boundaries stay aligned across disabled periods.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (xfer) begin
         unique case (state_q)
            TrkHdr: begin
               if (len != '0) begin
                  state_d = TrkBody;
                  rem_d   = len;
               end
            end
            TrkBody: begin
               rem_d = rem_q - wh_len_width_p'(1);
               if (rem_q == wh_len_width_p'(1)) state_d = TrkHdr;
            end
            default: state_d = TrkHdr;
         endcase
      end
   end

   always_comb begin
      ev        = '0;
      ev[XFER]  = en_i & xfer;
      ev[STALL] = en_i & v_i & ~ready_i;
      ev[IDLE]  = en_i & ~v_i;
      ev[PKT]   = en_i & xfer & (state_q == TrkHdr);
   end

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NumStats; i++) begin
         if (snap_i && clear_on_snap_p) begin
            cnt_d[i] = ctr_width_p'(ev[i]);
         end else if (ev[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + ctr_width_p'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/wh_link_stat_collector.sv
// Collects per-link wormhole statistics, snapshots them on request and streams the
// snapshot out as {link_id, stat_sel, value} records.
module wh_link_stat_collector
   import wh_link_stat_pkg::*;
#(
   parameter int unsigned num_links_p     = 8,
   parameter int unsigned ctr_width_p     = 32,
   parameter int unsigned wh_flit_width_p = 64,
   parameter int unsigned wh_len_offset_p = 0,
   parameter int unsigned wh_len_width_p  = 4,
   parameter bit          clear_on_snap_p = 1'b1
) (
   input logic                 clk_i,
   input logic                 reset_i,
   wh_link_stat_collector_if.slave bus
);

   localparam int unsigned LinkIdWidth = lg(num_links_p);
   localparam int unsigned NumRecs     = num_links_p * NumStats;
   localparam int unsigned IdxWidth    = lg(NumRecs);
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRecs - 1);

   typedef `WH_STAT_REC_S(LinkIdWidth, ctr_width_p) wh_stat_rec_s;

   wh_dump_state_e                                     state_q, state_d;
   logic [IdxWidth-1:0]                                idx_q;
   logic [num_links_p-1:0][NumStats-1:0][ctr_width_p-1:0] live;
   logic [NumRecs-1:0][ctr_width_p-1:0]                bank_q;
   logic                                               snap_ready, rec_v, rec_last;
   logic                                               snap_accept, rec_fire;
   wh_stat_rec_s                                       rec;

   assign snap_accept = bus.snap_v_i & snap_ready;
   assign rec_fire    = rec_v & bus.rec_ready_i;

   for (genvar l = 0; l < num_links_p; l++) begin : g_link
      wh_link_stat_tracker #(
         .ctr_width_p     (ctr_width_p),
         .wh_flit_width_p (wh_flit_width_p),
         .wh_len_offset_p (wh_len_offset_p),
         .wh_len_width_p  (wh_len_width_p),
         .clear_on_snap_p (clear_on_snap_p)
      ) u_tracker (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .en_i    (bus.en_i),
         .v_i     (bus.link_v_i[l]),
         .ready_i (bus.link_ready_i[l]),
         .data_i  (bus.link_data_i[l*wh_flit_width_p +: wh_flit_width_p]),
         .snap_i  (snap_accept),
         .cnt_o   (live[l])
      );
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= DumpIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DumpIdle: if (bus.snap_v_i) state_d = DumpRun;
         DumpRun:  if (bus.rec_ready_i && (idx_q == LastIdx)) state_d = DumpIdle;
         default:  state_d = DumpIdle;
      endcase
   end

   always_comb begin
      snap_ready = (state_q == DumpIdle);
      rec_v      = (state_q == DumpRun);
      rec_last   = rec_v && (idx_q == LastIdx);
   end

   // Flat bank index is link*4+stat_sel, which is exactly the record order.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idx_q  <= '0;
         bank_q <= '0;
      end else if (snap_accept) begin
         idx_q  <= '0;
         bank_q <= live;
      end else if (rec_fire) begin
         idx_q  <= idx_q + IdxWidth'(1);
      end
   end

   always_comb begin
      rec.link_id  = LinkIdWidth'(idx_q >> 2);
      rec.stat_sel = wh_stat_sel_e'(idx_q[1:0]);
      rec.value    = bank_q[idx_q];
   end

   assign bus.snap_ready_o = snap_ready;
   assign bus.rec_v_o      = rec_v;
   assign bus.rec_last_o   = rec_last;
   assign bus.rec_data_o   = rec;

endmodule

// File: tb/tb_wh_link_stat_collector.sv
// Directed bench: DUT A has two links with clear-on-snap, DUT B one link, 4-bit counters
// and no clear-on-snap.
module tb_wh_link_stat_collector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wh_link_stat_collector_if #(.num_links_p(2), .ctr_width_p(32), .wh_flit_width_p(64)) ifa ();
   wh_link_stat_collector_if #(.num_links_p(1), .ctr_width_p(4), .wh_flit_width_p(64)) ifb ();

   wh_link_stat_collector #(
      .num_links_p(2), .ctr_width_p(32), .wh_flit_width_p(64),
      .wh_len_offset_p(0), .wh_len_width_p(4), .clear_on_snap_p(1'b1)
   ) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa));

   wh_link_stat_collector #(
      .num_links_p(1), .ctr_width_p(4), .wh_flit_width_p(64),
      .wh_len_offset_p(0), .wh_len_width_p(4), .clear_on_snap_p(1'b0)
   ) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb));

   logic [34:0] cap_a [8];
   logic [6:0]  cap_b [4];
   int          cap_n, cap_unstable, cap_last_cnt, cap_last_idx;
   int unsigned exp_v [8];
   logic [34:0] ea;
   logic [6:0]  eb;

   task automatic drive_idle();
      ifa.en_i = 0; ifa.link_v_i = '0; ifa.link_ready_i = '0; ifa.link_data_i = '0;
      ifa.snap_v_i = 0; ifa.rec_ready_i = 0;
      ifb.en_i = 0; ifb.link_v_i = '0; ifb.link_ready_i = '0; ifb.link_data_i = '0;
      ifb.snap_v_i = 0; ifb.rec_ready_i = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1;
      drive_idle();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic snap_a();
      ifa.snap_v_i = 1;
      @(negedge clk);
      ifa.snap_v_i = 0;
   endtask

   task automatic snap_b();
      ifb.snap_v_i = 1;
      @(negedge clk);
      ifb.snap_v_i = 0;
   endtask

   // Collects one dump from DUT A; optional ready toggling; records stall stability.
   task automatic read_dump_a(input bit toggle);
      logic [35:0] hold;
      bit have_hold = 0;
      bit rdy;
      cap_n = 0; cap_unstable = 0; cap_last_cnt = 0; cap_last_idx = -1;
      for (int c = 0; c < 200; c++) begin
         rdy = toggle ? c[0] : 1'b1;
         ifa.rec_ready_i = rdy;
         if (ifa.rec_v_o) begin
            if (have_hold && ({ifa.rec_last_o, ifa.rec_data_o} !== hold)) cap_unstable++;
            if (rdy) begin
               if (cap_n < 8) cap_a[cap_n] = ifa.rec_data_o;
               have_hold = 0;
               if (ifa.rec_last_o) begin
                  cap_last_cnt++;
                  cap_last_idx = cap_n;
               end
               cap_n++;
               if (ifa.rec_last_o) break;
            end else begin
               hold = {ifa.rec_last_o, ifa.rec_data_o};
               have_hold = 1;
            end
         end
         @(negedge clk);
      end
      @(negedge clk);
      ifa.rec_ready_i = 0;
   endtask

   task automatic read_dump_b();
      cap_n = 0; cap_last_cnt = 0; cap_last_idx = -1;
      ifb.rec_ready_i = 1;
      for (int c = 0; c < 50; c++) begin
         if (ifb.rec_v_o) begin
            if (cap_n < 4) cap_b[cap_n] = ifb.rec_data_o;
            if (ifb.rec_last_o) begin
               cap_last_cnt++;
               cap_last_idx = cap_n;
            end
            cap_n++;
            if (ifb.rec_last_o) break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      ifb.rec_ready_i = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1;
      drive_idle();
      #1;
      checks++;
      if ({ifa.snap_ready_o, ifa.rec_v_o, ifa.rec_last_o} !== 3'b100) begin
         errors++;
         $display("FAIL reset_a_ctrl: got %b expected 100",
                  {ifa.snap_ready_o, ifa.rec_v_o, ifa.rec_last_o});
      end
      checks++;
      if ({ifb.snap_ready_o, ifb.rec_v_o, ifb.rec_last_o} !== 3'b100) begin
         errors++;
         $display("FAIL reset_b_ctrl: got %b expected 100",
                  {ifb.snap_ready_o, ifb.rec_v_o, ifb.rec_last_o});
      end
      @(negedge clk);
      rst = 0;
      snap_a();
      read_dump_a(1'b0);
      checks++;
      if (cap_n !== 8 || cap_last_idx !== 7) begin
         errors++;
         $display("FAIL reset_dump_len: got %0d/%0d expected 8/7", cap_n, cap_last_idx);
      end
      for (int i = 0; i < 8; i++) begin
         ea = '0; ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL reset_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
   endtask

   task automatic test_basic_counts();
      apply_reset();
      ifa.en_i = 1; ifa.link_v_i[0] = 1; ifa.link_ready_i[0] = 0;
      repeat (5) @(negedge clk);
      ifa.link_ready_i[0] = 1;
      repeat (3) @(negedge clk);
      ifa.link_v_i[0] = 0;
      repeat (2) @(negedge clk);
      ifa.en_i = 0;
      snap_a();
      read_dump_a(1'b0);
      exp_v = '{3, 5, 2, 3, 0, 0, 10, 0};
      for (int i = 0; i < 8; i++) begin
         ea = 35'(exp_v[i]); ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL basic_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
   endtask

   task automatic test_packet();
      apply_reset();
      ifa.en_i = 1; ifa.link_v_i[0] = 1; ifa.link_ready_i[0] = 1;
      ifa.link_data_i[63:0] = 64'h2;
      @(negedge clk);
      ifa.link_data_i[63:0] = 64'hF; ifa.link_ready_i[0] = 0;
      @(negedge clk);
      ifa.link_ready_i[0] = 1;
      @(negedge clk);
      ifa.link_data_i[63:0] = 64'h1;
      @(negedge clk);
      ifa.link_data_i[63:0] = 64'h0;
      @(negedge clk);
      ifa.link_v_i[0] = 0; ifa.en_i = 0;
      snap_a();
      read_dump_a(1'b0);
      exp_v = '{4, 1, 0, 2, 0, 0, 5, 0};
      for (int i = 0; i < 8; i++) begin
         ea = 35'(exp_v[i]); ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL packet_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      ifa.en_i = 1; ifa.link_v_i[1] = 1; ifa.link_ready_i[1] = 1;
      repeat (3) @(negedge clk);
      ifa.en_i = 0; ifa.link_v_i[1] = 0;
      snap_a();
      fork
         read_dump_a(1'b1);
         begin
            repeat (3) @(negedge clk);
            ifa.snap_v_i = 1;
            #1;
            checks++;
            if (ifa.snap_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL b2b_snap_ready_in_dump: got %b expected 0", ifa.snap_ready_o);
            end
            repeat (2) @(negedge clk);
            ifa.snap_v_i = 0;
         end
      join
      checks++;
      if (cap_n !== 8 || cap_last_cnt !== 1 || cap_last_idx !== 7) begin
         errors++;
         $display("FAIL b2b_dump_shape: got n=%0d last=%0d at %0d expected 8,1,7",
                  cap_n, cap_last_cnt, cap_last_idx);
      end
      checks++;
      if (cap_unstable !== 0) begin
         errors++;
         $display("FAIL b2b_stall_stable: got %0d changes expected 0", cap_unstable);
      end
      exp_v = '{0, 0, 3, 0, 3, 0, 0, 3};
      for (int i = 0; i < 8; i++) begin
         ea = 35'(exp_v[i]); ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL b2b_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
      @(negedge clk);
      checks++;
      if ({ifa.rec_v_o, ifa.snap_ready_o} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_no_queued_snap: got %b expected 01", {ifa.rec_v_o, ifa.snap_ready_o});
      end
   endtask

   task automatic test_clear_on_snap();
      apply_reset();
      ifa.en_i = 1; ifa.link_v_i[0] = 1; ifa.link_ready_i[0] = 1;
      repeat (2) @(negedge clk);
      ifa.snap_v_i = 1;
      @(negedge clk);
      ifa.snap_v_i = 0; ifa.en_i = 0; ifa.link_v_i[0] = 0;
      read_dump_a(1'b0);
      exp_v = '{2, 0, 0, 2, 0, 0, 2, 0};
      for (int i = 0; i < 8; i++) begin
         ea = 35'(exp_v[i]); ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL clear_snap1_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
      snap_a();
      read_dump_a(1'b0);
      exp_v = '{1, 0, 0, 1, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
         ea = 35'(exp_v[i]); ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL clear_snap2_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
   endtask

   task automatic test_no_clear();
      apply_reset();
      ifb.en_i = 1; ifb.link_v_i[0] = 1; ifb.link_ready_i[0] = 1;
      repeat (2) @(negedge clk);
      ifb.snap_v_i = 1;
      @(negedge clk);
      ifb.snap_v_i = 0; ifb.en_i = 0; ifb.link_v_i[0] = 0;
      read_dump_b();
      exp_v = '{2, 0, 0, 2, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         eb = 7'(exp_v[i]); eb[5:4] = 2'(i);
         checks++;
         if (cap_b[i] !== eb) begin
            errors++;
            $display("FAIL noclear_snap1_rec%0d: got %h expected %h", i, cap_b[i], eb);
         end
      end
      snap_b();
      read_dump_b();
      exp_v = '{3, 0, 0, 3, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         eb = 7'(exp_v[i]); eb[5:4] = 2'(i);
         checks++;
         if (cap_b[i] !== eb) begin
            errors++;
            $display("FAIL noclear_snap2_rec%0d: got %h expected %h", i, cap_b[i], eb);
         end
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      ifb.en_i = 1;
      repeat (20) @(negedge clk);
      ifb.en_i = 0;
      snap_b();
      read_dump_b();
      checks++;
      if (cap_n !== 4 || cap_last_idx !== 3) begin
         errors++;
         $display("FAIL sat_dump_len: got %0d/%0d expected 4/3", cap_n, cap_last_idx);
      end
      exp_v = '{0, 0, 15, 0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         eb = 7'(exp_v[i]); eb[5:4] = 2'(i);
         checks++;
         if (cap_b[i] !== eb) begin
            errors++;
            $display("FAIL sat_rec%0d: got %h expected %h", i, cap_b[i], eb);
         end
      end
   endtask

   task automatic test_reset_mid_dump();
      apply_reset();
      ifa.en_i = 1; ifa.link_v_i[0] = 1;
      repeat (3) @(negedge clk);
      ifa.en_i = 0; ifa.link_v_i[0] = 0;
      snap_a();
      ifa.rec_ready_i = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (ifa.rec_v_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_dumping: got rec_v %b expected 1", ifa.rec_v_o);
      end
      rst = 1;
      #1;
      checks++;
      if ({ifa.rec_v_o, ifa.snap_ready_o, ifa.rec_last_o} !== 3'b010) begin
         errors++;
         $display("FAIL midrst_abort: got %b expected 010",
                  {ifa.rec_v_o, ifa.snap_ready_o, ifa.rec_last_o});
      end
      @(negedge clk);
      rst = 0; ifa.rec_ready_i = 0;
      snap_a();
      read_dump_a(1'b0);
      for (int i = 0; i < 8; i++) begin
         ea = '0; ea[33:32] = 2'(i % 4); ea[34] = (i >= 4);
         checks++;
         if (cap_a[i] !== ea) begin
            errors++;
            $display("FAIL midrst_rec%0d: got %h expected %h", i, cap_a[i], ea);
         end
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_basic_counts();
      test_packet();
      test_back_to_back();
      test_clear_on_snap();
      test_no_clear();
      test_saturate();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wh_link_stat_collector.md
# wh_link_stat_collector

Parametrised, synthesizable wormhole link statistics collector for manycore pod-boundary ruche links. It observes `num_links_p` ready/valid wormhole links and keeps four saturating counters per link: transfer, stall, idle and packet. On request it snapshots every counter and streams the snapshot out as records over a valid/ready port. It sits beside the wormhole router columns and feeds a host-visible stat FIFO, which removes the need for simulation-only file dumps.

## Interface
- `num_links_p`, 8: number of observed links.
- `ctr_width_p`, 32: width of each counter and of the record value field.
- `wh_flit_width_p`, 64: observed flit width.
- `wh_len_offset_p`, 0: LSB position of the length field in a header flit.
- `wh_len_width_p`, 4: length field width; the value is the number of body flits after the header.
- `clear_on_snap_p`, 1: when 1, live counters restart on snapshot acceptance.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  counting enable; when 0, counters hold and wormhole tracking continues.
- `link_v_i`  in  num_links_p  per-link flit valid.
- `link_ready_i`  in  num_links_p  per-link downstream ready (ready_and_rev).
- `link_data_i`  in  num_links_p*wh_flit_width_p  per-link flit.
- `snap_v_i`  in  1  snapshot request.
- `snap_ready_o`  out  1  snapshot request accepted when high.
- `rec_v_o`  out  1  record valid.
- `rec_data_o`  out  lg(num_links_p)+2+ctr_width_p  record, packed as {link_id, stat_sel, value}.
- `rec_last_o`  out  1  marks the final record of a dump.
- `rec_ready_i`  in  1  record consumer ready.

## Operation
- Per-link event classification, only while `en_i` is high:
  - idle: `~v`.
  - stall: `v & ~ready`.
  - transfer: `v & ready`.
  - packet: a transfer while the link's tracker is in HDR.
  - Exactly one of idle, stall and transfer increments per cycle. Packet increments alongside transfer.
- Per-link wormhole tracker, always active regardless of `en_i`:
  - States are HDR and BODY, with a remaining-flit count `rem` of width `wh_len_width_p`.
  - HDR, transfer with len==0: stay in HDR.
  - HDR, transfer with len>0: go to BODY and load `rem` = len.
  - BODY, transfer: decrement `rem`. Return to HDR when `rem` reaches 1 before the decrement.
- Counters saturate at all-ones. A saturated counter never wraps.
- Snapshot acceptance happens in the cycle where `snap_v_i & snap_ready_o`:
  - Every counter's registered value (excluding this cycle's event) is copied into the snapshot bank.
  - If `clear_on_snap_p`, each live counter loads the value of this cycle's event (0 or 1). Otherwise it increments normally.
- Dump FSM states:
  - IDLE: `snap_ready_o`=1, `rec_v_o`=0. Goes to DUMP on acceptance.
  - DUMP: presents records in the order link 0..num_links_p-1, and within each link stat_sel 0=xfer, 1=stall, 2=idle, 3=pkt.
  - Index advances on `rec_v_o & rec_ready_i`.
  - `rec_last_o` is asserted with link num_links_p-1, stat_sel 3. Acceptance of that record returns the FSM to IDLE.
- `snap_ready_o`=0 throughout DUMP. A `snap_v_i` during DUMP is ignored and not queued.
- Live counting continues during DUMP. The snapshot bank stays frozen until the next acceptance.

## Timing
- Reset (asynchronous) drives:
  - all live and snapshot counters to 0;
  - trackers to HDR with `rem`=0;
  - FSM to IDLE, so `snap_ready_o`=1, `rec_v_o`=0 and `rec_last_o`=0.
- A counter reflects a cycle-t event at t+1.
- Snapshot accepted at t: first `rec_v_o` at t+1. With `rec_ready_i` held high, one record per cycle, 4*num_links_p cycles in total. `snap_ready_o` returns to 1 in the cycle after the last record is accepted.
- `rec_data_o` and `rec_last_o` are stable while `rec_v_o & ~rec_ready_i`. Valid never drops without acceptance.
- Reset mid-dump aborts the dump immediately. No partial `rec_last_o` is issued.

## Structure
- Package `wh_link_stat_pkg` holds:
  - the `wh_stat_sel_e` enum (XFER, STALL, IDLE, PKT);
  - the FSM state enum;
  - the `wh_stat_rec_s` record struct macro parametrised by link-id and counter width.
- Sub-module `wh_link_stat_tracker`, instantiated once per link, holds the HDR/BODY FSM, `rem`, and four saturating counters with load/clear. The top holds the snapshot bank, record mux and dump FSM.

## Test plan
- Single link, `v`=1 with `ready`=0 for 5 cycles, then `ready`=1 for 3 cycles, then `v`=0 for 2 cycles, then snap -> record for link 0 reads xfer=3, stall=5, idle=2.
- Header with len=2, then 2 body flits, then header with len=0 -> pkt=2, xfer=4. A body flit whose len bits are nonzero must not count as a packet.
- `ctr_width_p`=4, 20 idle cycles -> idle=15 (saturated), no wrap.
- Snap with `rec_ready_i` toggling every other cycle -> 4*num_links_p records in order, data stable while stalled, `rec_last_o` only on the final record. A second `snap_v_i` mid-dump is ignored.
- `clear_on_snap_p`=1, snap accepted in the same cycle as a transfer -> snapshot excludes that transfer and live xfer=1 afterwards. With `clear_on_snap_p`=0 the live count is the snapshot value plus 1.
- Reset asserted mid-dump -> `rec_v_o`=0 and `snap_ready_o`=1 immediately. Counters are 0 and the next snap reports all zeros.
